// File: rtl/flp_stream_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | flp_stream_accumulator: streams log2 terms, truncating FLP running sum.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module flp_stream_accumulator #(
  parameter int NUM_INPUTS = 10,
  parameter int LANES      = 2,
  parameter int IN_WIDTH   = 8,
  parameter int EXP_WIDTH  = 9,
  parameter int MANT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*IN_WIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_WIDTH-1:0]      exp,
  output logic [MANT_WIDTH-1:0]     mant,
  output logic                      ovf
);

  localparam int BEATS  = NUM_INPUTS / LANES;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [LANE_W-1:0]    LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [EXP_WIDTH-1:0] MAX_SHIFT = EXP_WIDTH'(MANT_WIDTH);

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]                state_q, state_d;
  logic [LANES*IN_WIDTH-1:0] beat_q, beat_d;
  logic [LANE_W-1:0]         lane_q, lane_d;
  logic [BEAT_W-1:0]         cnt_q, cnt_d;
  logic [EXP_WIDTH-1:0]      acc_exp_q, acc_exp_d;
  logic [MANT_WIDTH-1:0]     acc_mant_q, acc_mant_d;
  logic                      empty_q, empty_d;
  logic                      ovf_q, ovf_d;

  logic [IN_WIDTH-1:0]     elem;
  logic [EXP_WIDTH-1:0]    elem_exp;
  logic [EXP_WIDTH-1:0]    big_exp;
  logic [EXP_WIDTH-1:0]    shift;
  logic [MANT_WIDTH:0]     big_sig;
  logic [MANT_WIDTH:0]     small_sig;
  logic [MANT_WIDTH:0]     aligned_sig;
  logic [MANT_WIDTH+1:0]   sum;
  logic                    carry;
  logic                    sat;
  logic [EXP_WIDTH-1:0]    sum_exp;
  logic [MANT_WIDTH-1:0]   sum_mant;

  // Add path: accumulator + (elem, mant=0), both with hidden leading one.
  always_comb begin
    elem      = beat_q[int'(lane_q)*IN_WIDTH +: IN_WIDTH];
    elem_exp  = EXP_WIDTH'(elem);
    big_exp   = acc_exp_q;
    big_sig   = {1'b1, acc_mant_q};
    small_sig = {1'b1, {MANT_WIDTH{1'b0}}};
    shift     = acc_exp_q - elem_exp;
    if (acc_exp_q < elem_exp) begin
      big_exp   = elem_exp;
      big_sig   = {1'b1, {MANT_WIDTH{1'b0}}};
      small_sig = {1'b1, acc_mant_q};
      shift     = elem_exp - acc_exp_q;
    end
    aligned_sig = (shift > MAX_SHIFT) ? '0 : (small_sig >> shift);
    sum         = {1'b0, big_sig} + {1'b0, aligned_sig};
    carry       = sum[MANT_WIDTH+1];
    sat         = carry && (big_exp == {EXP_WIDTH{1'b1}});
    sum_exp     = carry ? (big_exp + 1'b1) : big_exp;
    sum_mant    = carry ? sum[MANT_WIDTH:1] : sum[MANT_WIDTH-1:0];
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    lane_d     = lane_q;
    cnt_d      = cnt_q;
    acc_exp_d  = acc_exp_q;
    acc_mant_d = acc_mant_q;
    empty_d    = empty_q;
    ovf_d      = ovf_q;
    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          beat_d  = in_data;
          lane_d  = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        if (empty_q) begin
          acc_exp_d  = elem_exp;
          acc_mant_d = '0;
          empty_d    = 1'b0;
        end else if (!ovf_q) begin
          if (sat) begin
            acc_exp_d  = '1;
            acc_mant_d = '1;
            ovf_d      = 1'b1;
          end else begin
            acc_exp_d  = sum_exp;
            acc_mant_d = sum_mant;
          end
        end
        if (lane_q == LAST_LANE) begin
          lane_d = '0;
          if (cnt_q == LAST_BEAT) begin
            state_d = S_OUT;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_LOAD;
          end
        end else begin
          lane_d = lane_q + 1'b1;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_LOAD;
          empty_d = 1'b1;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_LOAD;
      beat_q     <= '0;
      lane_q     <= '0;
      cnt_q      <= '0;
      acc_exp_q  <= '0;
      acc_mant_q <= '0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      lane_q     <= lane_d;
      cnt_q      <= cnt_d;
      acc_exp_q  <= acc_exp_d;
      acc_mant_q <= acc_mant_d;
      empty_q    <= empty_d;
      ovf_q      <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = (state_q == S_OUT);
  assign exp       = acc_exp_q;
  assign mant      = acc_mant_q;
  assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_flp_stream_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_flp_stream_accumulator: directed vectors on default and 8-bit-exp DUT.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_flp_stream_accumulator;

  typedef struct packed {
    logic [79:0] elems;
    logic [8:0]  exp9;
    logic [7:0]  mant9;
    logic        ovf9;
    logic [7:0]  exp8;
    logic [7:0]  mant8;
    logic        ovf8;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, ovf_a;
  logic [8:0]  exp_a;
  logic [7:0]  mant_a;
  logic        in_ready_b, out_valid_b, ovf_b;
  logic [7:0]  exp_b;
  logic [7:0]  mant_b;

  int checks = 0;
  int errors = 0;
  vec_t vecs [9];

  always #5 clk = ~clk;

  flp_stream_accumulator dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
    .exp(exp_a), .mant(mant_a), .ovf(ovf_a)
  );

  flp_stream_accumulator #(.EXP_WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
    .exp(exp_b), .mant(mant_b), .ovf(ovf_b)
  );

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [79:0] el, input logic [8:0] e9, input logic [7:0] m9,
                              input logic o9, input logic [7:0] e8, input logic [7:0] m8,
                              input logic o8);
    vec_t v;
    v.elems = el; v.exp9 = e9; v.mant9 = m9; v.ovf9 = o9;
    v.exp8 = e8; v.mant8 = m8; v.ovf8 = o8;
    return v;
  endfunction

  task automatic send_beat(input logic [15:0] d, output int gap);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready_a && w < 50) begin
      tick();
      w++;
    end
    if (!in_ready_a) check("in_ready_timeout", 32'(in_ready_a), 32'd1);
    tick();
    in_valid = 1'b0;
    gap = w;
  endtask

  task automatic feed_vec(input vec_t v, input string tag);
    int gap;
    int lat;
    bit gap_ok;
    gap_ok = 1'b1;
    for (int b = 0; b < 5; b++) begin
      send_beat(v.elems[b*16 +: 16], gap);
      if (b > 0 && gap != 2) gap_ok = 1'b0;
    end
    check({tag, "_beat_gap"}, 32'(gap_ok), 32'd1);
    lat = 0;
    while (!out_valid_a && lat < 50) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd2);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    feed_vec(v, tag);
    check({tag, "_exp_a"},  32'(exp_a),  32'(v.exp9));
    check({tag, "_mant_a"}, 32'(mant_a), 32'(v.mant9));
    check({tag, "_ovf_a"},  32'(ovf_a),  32'(v.ovf9));
    check({tag, "_exp_b"},  32'(exp_b),  32'(v.exp8));
    check({tag, "_mant_b"}, 32'(mant_b), 32'(v.mant8));
    check({tag, "_ovf_b"},  32'(ovf_b),  32'(v.ovf8));
    check({tag, "_valid_b"}, 32'(out_valid_b), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_clear"}, 32'({out_valid_a, out_valid_b}), 32'd0);
    check({tag, "_ready_back"},  32'({in_ready_a, in_ready_b}), 32'd3);
  endtask

  initial begin
    int gap;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    vecs[0] = mk(80'h0,                                  9'd3,   8'h40, 1'b0, 8'd3,   8'h40, 1'b0);
    vecs[1] = mk(80'd10,                                 9'd10,  8'h00, 1'b0, 8'd10,  8'h00, 1'b0);
    vecs[2] = mk({8'd10, 72'h0},                         9'd10,  8'h02, 1'b0, 8'd10,  8'h02, 1'b0);
    vecs[3] = mk({10{8'd5}},                             9'd8,   8'h40, 1'b0, 8'd8,   8'h40, 1'b0);
    vecs[4] = mk({8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0},
                                                         9'd9,   8'hFF, 1'b0, 8'd9,   8'hFF, 1'b0);
    vecs[5] = mk({10{8'd255}},                           9'd258, 8'h40, 1'b0, 8'hFF,  8'hFF, 1'b1);
    vecs[6] = mk(80'h0,                                  9'd3,   8'h40, 1'b0, 8'd3,   8'h40, 1'b0);
    vecs[7] = mk({10{8'd254}},                           9'd257, 8'h40, 1'b0, 8'hFF,  8'hFF, 1'b1);
    vecs[8] = mk({8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0},
                                                         9'd9,   8'hFF, 1'b0, 8'd9,   8'hFF, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({out_valid_a, exp_a, mant_a, ovf_a}), 32'd0);
    rst = 1'b0;
    tick();
    check("reset_in_ready", 32'(in_ready_a), 32'd1);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Stall in OUT with a beat offered; a consumed stray beat would corrupt the next sum.
    feed_vec(vecs[0], "stall");
    in_valid = 1'b1;
    in_data  = 16'h0A0A;
    for (int c = 0; c < 20; c++) begin
      tick();
      check($sformatf("stall_hold%0d", c), 32'({out_valid_a, in_ready_a, exp_a, mant_a}),
            32'({1'b1, 1'b0, 9'd3, 8'h40}));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    run_vec(vecs[3], "after_stall");

    // Reset while the third beat of a vector is being serialised.
    send_beat(vecs[0].elems[15:0], gap);
    send_beat(vecs[0].elems[31:16], gap);
    send_beat(vecs[0].elems[47:32], gap);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_outputs", 32'({out_valid_a, exp_a, mant_a, ovf_a}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("midrst_in_ready", 32'(in_ready_a), 32'd1);
    run_vec(vecs[0], "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
